irq_encoder: RTL and testbench

Sequential priority encoder: the reverse of the address decoder. It captures rising edges on N one-hot request lines into a pending register and presents the highest-priority unmasked pending line as a binary code on `Y` with a valid/ack handshake. It sits between peripheral request lines and the control unit, which consumes the code as an interrupt/branch vector index.

---
 rtl/irq_encoder.sv | 74 +++++++
 tb/tb_irq_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/irq_encoder.sv
// irq_encoder: edge-captured pending lines, lowest unmasked index presented on Y with valid/ack.
// Optional dropped-event counter on MISS when IRQ_MISS_CNT_EN is defined.
module irq_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] REQ,
  input  logic         mask_we,
  input  logic [N-1:0] MASK_D,
  input  logic         ack,
  output logic [W-1:0] Y,
  output logic         valid,
  output logic [N-1:0] PEND,
  output logic [7:0]   MISS
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [N-1:0] prev_q, pend_q, pend_d, mask_q, mask_d, rise, clr, cand;
  logic [W-1:0] y_q, y_d, sel;
  logic         grant;
  always_comb begin
    rise = REQ & ~prev_q;
    clr = (state_q == BUSY && ack) ? N'(1) << y_q : '0;
    // a new rise on a bit being acked keeps it pending
    pend_d = (pend_q & ~clr) | rise;
    mask_d = mask_we ? MASK_D : mask_q;
    cand = pend_q & ~mask_q;
    sel = '0;
    for (int i = N - 1; i >= 0; i--) sel = cand[i] ? W'(i) : sel;
    grant = state_q == IDLE && enable && |cand;
    y_d = grant ? sel : y_q;
  end
  always_comb begin
    state_d = state_q == IDLE ? (grant ? BUSY : IDLE) : (ack ? IDLE : BUSY);
  end
  always_comb begin
    valid = state_q == BUSY;
    Y = y_q;
    PEND = pend_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= REQ;
      pend_q <= pend_d;
      mask_q <= mask_d;
      y_q <= y_d;
    end
  end
`ifdef IRQ_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;
  logic       hit;
  always_comb begin
    hit = |(rise & pend_q & ~clr);
    miss_d = (hit && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) miss_q <= '0;
    else miss_q <= miss_d;
  end
  assign MISS = miss_q;
`else
  assign MISS = '0;
`endif
endmodule

// File: tb/tb_irq_encoder.sv
// tb_irq_encoder: directed stimulus; expected grant codes queued, checked by a separate monitor.
module tb_irq_encoder;
  logic       clk = 0, rst_n = 0, enable = 0, mask_we = 0, ack = 0;
  logic [7:0] REQ = 0, MASK_D = 0, PEND, MISS;
  logic [2:0] Y, y_prev = 0;
  logic       valid, v_prev = 0;
  int         tests = 0, fails = 0, exp_miss;
  logic [2:0] sb[$];

  irq_encoder #(.N(8), .W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .REQ(REQ), .mask_we(mask_we),
    .MASK_D(MASK_D), .ack(ack), .Y(Y), .valid(valid), .PEND(PEND), .MISS(MISS)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (valid && !v_prev) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL grant_unexpected: got Y=%0d, required no grant", Y);
      end else begin
        logic [2:0] e;
        e = sb.pop_front();
        if (Y !== e) begin
          fails++;
          $display("FAIL grant_y: got Y=%0d, required %0d", Y, e);
        end
      end
    end else if (valid && v_prev) begin
      tests++;
      if (Y !== y_prev) begin
        fails++;
        $display("FAIL hold_y: Y changed to %0d while valid, required %0d", Y, y_prev);
      end
    end
    v_prev = valid;
    y_prev = Y;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_pend", PEND, 0);
    chk("rst_valid", valid, 0);
    chk("rst_y", Y, 0);
    chk("rst_miss", MISS, 0);
    rst_n = 1;
    // single request
    REQ = 8'b0000_0100; enable = 1; sb.push_back(3'd2);
    cyc(1);
    chk("single_pend", PEND, 8'h04);
    chk("single_latency", valid, 0);
    cyc(1);
    chk("single_valid", valid, 1);
    ack = 1;
    cyc(1);
    chk("single_ack_valid", valid, 0);
    chk("single_ack_pend", PEND, 0);
    ack = 0; REQ = 0;
    cyc(1);
    // priority
    REQ = 8'b1001_0000; sb.push_back(3'd4); sb.push_back(3'd7);
    cyc(1);
    REQ = 0;
    chk("prio_pend", PEND, 8'h90);
    cyc(1);
    ack = 1;
    cyc(1);
    chk("prio_gap", valid, 0);
    chk("prio_pend2", PEND, 8'h80);
    ack = 0;
    cyc(1);
    chk("prio_second", valid, 1);
    ack = 1;
    cyc(1);
    chk("prio_pend0", PEND, 0);
    ack = 0;
    // mask and enable
    mask_we = 1; MASK_D = 8'h01; REQ = 8'h03; sb.push_back(3'd1);
    cyc(1);
    mask_we = 0; REQ = 0;
    cyc(1);
    chk("mask_valid", valid, 1);
    ack = 1;
    cyc(1);
    chk("mask_pend0_stays", PEND, 8'h01);
    ack = 0; enable = 0; mask_we = 1; MASK_D = 0;
    cyc(1);
    mask_we = 0;
    cyc(2);
    chk("enable_off_valid", valid, 0);
    chk("enable_off_pend", PEND, 8'h01);
    enable = 1; sb.push_back(3'd0);
    cyc(1);
    chk("enable_on_grant", valid, 1);
    ack = 1;
    cyc(1);
    ack = 0;
    chk("enable_pend0", PEND, 0);
    // hold under change
    REQ = 8'h20; sb.push_back(3'd5);
    cyc(1);
    REQ = 0;
    cyc(1);
    REQ = 8'h01; enable = 0; mask_we = 1; MASK_D = 8'h20;
    cyc(1);
    chk("hold_pend", PEND, 8'h21);
    mask_we = 0; REQ = 0;
    cyc(2);
    chk("hold_valid", valid, 1);
    chk("hold_y5", Y, 5);
    enable = 1; ack = 1; sb.push_back(3'd0);
    cyc(1);
    ack = 0;
    chk("hold_ack_pend", PEND, 8'h01);
    cyc(1);
    ack = 1;
    cyc(1);
    ack = 0; mask_we = 1; MASK_D = 0;
    cyc(1);
    mask_we = 0;
    chk("hold_pend0", PEND, 0);
    // set beats clear
    REQ = 8'h08; sb.push_back(3'd3);
    cyc(1);
    REQ = 0;
    cyc(1);
    REQ = 8'h08; ack = 1; sb.push_back(3'd3);
    cyc(1);
    chk("sbc_pend", PEND, 8'h08);
    chk("sbc_valid", valid, 0);
    ack = 0; REQ = 0;
    cyc(1);
    chk("sbc_regrant", valid, 1);
    // reset while busy
    REQ = 8'h10; rst_n = 0;
    cyc(1);
    REQ = 0; rst_n = 1;
    chk("midrst_valid", valid, 0);
    chk("midrst_y", Y, 0);
    chk("midrst_pend", PEND, 0);
    cyc(3);
    chk("midrst_quiet", valid, 0);
    // dropped events: enable off so nothing is granted
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      REQ = 8'h40; cyc(1); REQ = 0; cyc(1);
    end
`ifdef IRQ_MISS_CNT_EN
    exp_miss = 2;
`else
    exp_miss = 0;
`endif
    chk("miss_three", MISS, exp_miss);
    for (int i = 0; i < 297; i++) begin
      REQ = 8'h40; cyc(1); REQ = 0; cyc(1);
    end
`ifdef IRQ_MISS_CNT_EN
    exp_miss = 255;
`else
    exp_miss = 0;
`endif
    chk("miss_sat", MISS, exp_miss);
    chk("miss_pend", PEND, 8'h40);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    chk("miss_rst", MISS, 0);
    cyc(2);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
